ps2_receive: RTL and testbench



---
 rtl/ps2_pkg.sv | 19 +
 rtl/ps2_line_filter.sv | 47 ++++
 rtl/ps2_receive.sv | 165 ++++++++++++++++
 tb/tb_ps2_receive.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: state encodings, receive error codes and frame length.
// Used by both the PS/2 receiver and the host-to-device sender.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SHIFT     = 3'd1,
        ST_CHECK     = 3'd2,
        ST_WAIT_IDLE = 3'd3
    } ps2_state_e;

    localparam logic [1:0] ERR_START   = 2'd0;
    localparam logic [1:0] ERR_PARITY  = 2'd1;
    localparam logic [1:0] ERR_STOP    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam int PS2_FRAME_BITS = 11;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a run-length glitch filter for one PS/2 line.
// The filtered level changes only after FILTER_LEN consecutive identical samples.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic qzt_clk,
    input  logic reset,
    input  logic line_in,
    output logic level
);

    localparam logic [7:0] FLEN = 8'(FILTER_LEN);

    logic       sync1_q, sync2_q;
    logic       level_q, level_d;
    logic [7:0] run_q, run_d;

    // Idle PS/2 lines float high, so every stage resets to 1.
    always_ff @(posedge qzt_clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            run_q   <= '0;
        end else begin
            sync1_q <= line_in;
            sync2_q <= sync1_q;
            level_q <= level_d;
            run_q   <= run_d;
        end
    end

    always_comb begin
        level_d = level_q;
        run_d   = '0;
        if (sync2_q != level_q) begin
            if (run_q + 8'd1 == FLEN) begin
                level_d = sync2_q;
            end else begin
                run_d = run_q + 8'd1;
            end
        end
    end

    assign level = level_q;

endmodule

// File: rtl/ps2_receive.sv
// PS/2 device-to-host frame receiver: filters PS2C/PS2D, shifts 11-bit frames and checks them.
// Define PS2_RX_TIMEOUT_EN to include the inter-edge timeout (error code 3).
module ps2_receive
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       qzt_clk,
    input  logic       reset,
    input  logic       PS2C,
    input  logic       PS2D,
    input  logic       inhibit,
    output logic [7:0] data,
    output logic       valid,
    output logic       err,
    output logic [1:0] err_code,
    output logic       busy,
    output logic [2:0] status
);

    localparam logic [3:0] FRAME_BITS = 4'(PS2_FRAME_BITS);

    logic c_filt, d_filt, fall;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .qzt_clk (qzt_clk),
        .reset   (reset),
        .line_in (PS2C),
        .level   (c_filt)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
        .qzt_clk (qzt_clk),
        .reset   (reset),
        .line_in (PS2D),
        .level   (d_filt)
    );

    ps2_state_e  state_q, state_d;
    logic [3:0]  nbits_q, nbits_d;
    logic [10:0] shreg_q, shreg_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [1:0]  err_code_q, err_code_d;
    logic        c_prev_q;

`ifdef PS2_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tcnt_q, tcnt_d;

    always_ff @(posedge qzt_clk or posedge reset) begin
        if (reset) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end
`endif

    assign fall = c_prev_q & ~c_filt;

    always_ff @(posedge qzt_clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            nbits_q    <= '0;
            shreg_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= '0;
            c_prev_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            nbits_q    <= nbits_d;
            shreg_q    <= shreg_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            c_prev_q   <= c_filt;
        end
    end

    // Bits arrive LSB first, so after 11 falls: [0]=start, [8:1]=data, [9]=parity, [10]=stop.
    always_comb begin
        state_d    = state_q;
        nbits_d    = nbits_q;
        shreg_d    = shreg_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
`ifdef PS2_RX_TIMEOUT_EN
        tcnt_d     = '0;
`endif
        if (inhibit) begin
            state_d = ST_IDLE;
            nbits_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fall) begin
                        shreg_d = {d_filt, shreg_q[10:1]};
                        nbits_d = 4'd1;
                        state_d = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (fall) begin
                        shreg_d = {d_filt, shreg_q[10:1]};
                        nbits_d = nbits_q + 4'd1;
                        if (nbits_q + 4'd1 == FRAME_BITS) begin
                            state_d = ST_CHECK;
                        end
`ifdef PS2_RX_TIMEOUT_EN
                    end else if (tcnt_q == TLAST) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_TIMEOUT;
                        nbits_d    = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
`endif
                    end
                end
                ST_CHECK: begin
                    err_d = 1'b1;
                    if (shreg_q[0] != 1'b0) begin
                        err_code_d = ERR_START;
                    end else if (^shreg_q[9:1] != 1'b1) begin
                        err_code_d = ERR_PARITY;
                    end else if (shreg_q[10] != 1'b1) begin
                        err_code_d = ERR_STOP;
                    end else begin
                        err_d   = 1'b0;
                        valid_d = 1'b1;
                        data_d  = shreg_q[8:1];
                    end
                    nbits_d = '0;
                    state_d = ST_WAIT_IDLE;
                end
                ST_WAIT_IDLE: begin
                    if (c_filt) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    nbits_d = '0;
                end
            endcase
        end
    end

    assign data     = data_q;
    assign valid    = valid_q;
    assign err      = err_q;
    assign err_code = err_code_q;
    assign busy     = (state_q != ST_IDLE);
    assign status   = state_q;

endmodule

// File: tb/tb_ps2_receive.sv
// Directed bench for ps2_receive with scaled-down PS/2 timing (80-cycle PS2C period, 2000-cycle timeout).
// Covers good/bad frames, inhibit, timeout (build dependent), glitch rejection and async reset.
module tb_ps2_receive;

    localparam int HALF = 40;

    logic       qzt_clk = 1'b0;
    logic       reset;
    logic       ps2c;
    logic       ps2d;
    logic       inhibit;
    logic [7:0] data;
    logic       valid;
    logic       err;
    logic [1:0] err_code;
    logic       busy;
    logic [2:0] status;

    int         vectors = 0;
    int         miscompares = 0;
    int         valid_cnt = 0;
    int         err_cnt = 0;
    int         both_cnt = 0;
    logic [7:0] last_data = 8'h00;
    logic [1:0] last_code = 2'd0;
    int         v0, e0;

    always #10 qzt_clk = ~qzt_clk;

    ps2_receive #(
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (2000)
    ) dut (
        .qzt_clk  (qzt_clk),
        .reset    (reset),
        .PS2C     (ps2c),
        .PS2D     (ps2d),
        .inhibit  (inhibit),
        .data     (data),
        .valid    (valid),
        .err      (err),
        .err_code (err_code),
        .busy     (busy),
        .status   (status)
    );

    // Pulses last one cycle, so sampling on the falling edge sees each exactly once.
    always @(negedge qzt_clk) begin
        if (valid) begin
            valid_cnt = valid_cnt + 1;
            last_data = data;
        end
        if (err) begin
            err_cnt   = err_cnt + 1;
            last_code = err_code;
        end
        if (valid && err) both_cnt = both_cnt + 1;
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge qzt_clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drives nbits bits of a device frame; glitch_bit < 0 means no glitch.
    task automatic applyStimulus(input logic [7:0] byte_v, input logic par_ok, input logic stop_v,
                                 input int nbits, input int glitch_bit);
        logic [10:0] frame;
        logic        par;
        par   = par_ok ? ~^byte_v : ^byte_v;
        frame = {stop_v, par, byte_v, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2d = frame[i];
            if (i == glitch_bit) begin
                waitCycles(15);
                ps2c = 1'b0;
                waitCycles(3);
                ps2c = 1'b1;
                waitCycles(HALF - 18);
            end else begin
                waitCycles(HALF);
            end
            ps2c = 1'b0;
            waitCycles(HALF);
            ps2c = 1'b1;
        end
        ps2d = 1'b1;
    endtask

    initial begin
        reset   = 1'b1;
        ps2c    = 1'b1;
        ps2d    = 1'b1;
        inhibit = 1'b0;
        waitCycles(5);
        checkOutput("reset_data",     32'(data),     32'h00);
        checkOutput("reset_valid",    32'(valid),    32'd0);
        checkOutput("reset_err",      32'(err),      32'd0);
        checkOutput("reset_err_code", 32'(err_code), 32'd0);
        checkOutput("reset_busy",     32'(busy),     32'd0);
        checkOutput("reset_status",   32'(status),   32'd0);
        reset = 1'b0;
        waitCycles(20);

        $display("[TB] good frame 0xFA");
        v0 = valid_cnt; e0 = err_cnt;
        applyStimulus(8'hFA, 1'b1, 1'b1, 11, -1);
        checkOutput("fa_busy_wait",   32'(busy),   32'd1);
        checkOutput("fa_status_wait", 32'(status), 32'd3);
        waitCycles(30);
        checkOutput("fa_busy_idle",   32'(busy),   32'd0);
        checkOutput("fa_status_idle", 32'(status), 32'd0);
        checkOutput("fa_valid_pulses", 32'(valid_cnt - v0), 32'd1);
        checkOutput("fa_err_pulses",   32'(err_cnt - e0),   32'd0);
        checkOutput("fa_pulse_data",   32'(last_data),      32'hFA);
        checkOutput("fa_data_held",    32'(data),           32'hFA);

        $display("[TB] frame 0x00 with parity 0");
        v0 = valid_cnt; e0 = err_cnt;
        applyStimulus(8'h00, 1'b0, 1'b1, 11, -1);
        waitCycles(30);
        checkOutput("par_err_pulses",   32'(err_cnt - e0),   32'd1);
        checkOutput("par_valid_pulses", 32'(valid_cnt - v0), 32'd0);
        checkOutput("par_code_pulse",   32'(last_code),      32'd1);
        checkOutput("par_code_held",    32'(err_code),       32'd1);
        checkOutput("par_data_kept",    32'(data),           32'hFA);

        $display("[TB] frame 0x55 with stop 0");
        v0 = valid_cnt; e0 = err_cnt;
        applyStimulus(8'h55, 1'b1, 1'b0, 11, -1);
        waitCycles(30);
        checkOutput("stop_err_pulses",   32'(err_cnt - e0),   32'd1);
        checkOutput("stop_valid_pulses", 32'(valid_cnt - v0), 32'd0);
        checkOutput("stop_code",         32'(err_code),       32'd2);
        checkOutput("stop_status",       32'(status),         32'd0);

        $display("[TB] inhibit after 6 bits");
        v0 = valid_cnt; e0 = err_cnt;
        applyStimulus(8'h81, 1'b1, 1'b1, 6, -1);
        checkOutput("inh_status_shift", 32'(status), 32'd1);
        inhibit = 1'b1;
        waitCycles(3);
        checkOutput("inh_status_idle", 32'(status), 32'd0);
        inhibit = 1'b0;
        waitCycles(10);
        checkOutput("inh_err_pulses",   32'(err_cnt - e0),   32'd0);
        checkOutput("inh_valid_pulses", 32'(valid_cnt - v0), 32'd0);
        checkOutput("inh_busy",         32'(busy),           32'd0);

        $display("[TB] five bits then PS2C held high");
        v0 = valid_cnt; e0 = err_cnt;
        applyStimulus(8'h0F, 1'b1, 1'b1, 5, -1);
        checkOutput("to_status_shift", 32'(status), 32'd1);
        waitCycles(2500);
`ifdef PS2_RX_TIMEOUT_EN
        checkOutput("to_err_pulses", 32'(err_cnt - e0), 32'd1);
        checkOutput("to_code",       32'(err_code),     32'd3);
        checkOutput("to_status",     32'(status),       32'd0);
`else
        checkOutput("to_err_pulses", 32'(err_cnt - e0), 32'd0);
        checkOutput("to_status",     32'(status),       32'd1);
        checkOutput("to_busy",       32'(busy),         32'd1);
        inhibit = 1'b1;
        waitCycles(3);
        inhibit = 1'b0;
        waitCycles(3);
        checkOutput("to_inh_status", 32'(status),       32'd0);
`endif
        checkOutput("to_valid_pulses", 32'(valid_cnt - v0), 32'd0);

        $display("[TB] 3-cycle PS2C glitch inside frame 0x3C");
        v0 = valid_cnt; e0 = err_cnt;
        applyStimulus(8'h3C, 1'b1, 1'b1, 11, 5);
        waitCycles(30);
        checkOutput("gl_valid_pulses", 32'(valid_cnt - v0), 32'd1);
        checkOutput("gl_err_pulses",   32'(err_cnt - e0),   32'd0);
        checkOutput("gl_data",         32'(data),           32'h3C);

        $display("[TB] reset after 4 bits");
        applyStimulus(8'hC3, 1'b1, 1'b1, 4, -1);
        checkOutput("rst_busy_before", 32'(busy), 32'd1);
        #5;
        reset = 1'b1;
        #1;
        checkOutput("rst_data",     32'(data),     32'h00);
        checkOutput("rst_valid",    32'(valid),    32'd0);
        checkOutput("rst_err",      32'(err),      32'd0);
        checkOutput("rst_err_code", 32'(err_code), 32'd0);
        checkOutput("rst_busy",     32'(busy),     32'd0);
        checkOutput("rst_status",   32'(status),   32'd0);
        waitCycles(3);
        reset = 1'b0;
        waitCycles(20);
        v0 = valid_cnt; e0 = err_cnt;
        applyStimulus(8'hAA, 1'b1, 1'b1, 11, -1);
        waitCycles(30);
        checkOutput("aa_valid_pulses", 32'(valid_cnt - v0), 32'd1);
        checkOutput("aa_err_pulses",   32'(err_cnt - e0),   32'd0);
        checkOutput("aa_data",         32'(data),           32'hAA);

        checkOutput("never_valid_and_err", 32'(both_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
